// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} kp_state_t;

  localparam int unsigned NUM_COLS = 4;
  localparam int unsigned NUM_ROWS = 4;
  localparam logic [NUM_COLS-1:0] COL_IDLE = 4'b1111;

  // Lowest-numbered row that reads low; rows are active-low.
  function automatic logic [1:0] low_row(input logic [NUM_ROWS-1:0] rows);
    low_row = 2'd0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      if (!rows[i]) low_row = 2'(i);
    end
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for asynchronous keypad rows; resets to all ones (rows idle high).
module keypad_sync #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
    end
  end

  assign dout = sync_q;

endmodule

// File: rtl/module_keypad_scan.sv
// 4x4 matrix keypad scanner with press/release debounce and column/row code output.
// Define KEYPAD_REPEAT_EN to add auto-repeat pulses while a key is held.
module module_keypad_scan
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV        = 1000,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned REPEAT_CYCLES   = 5000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_ROWS-1:0] filas_i,
  output logic [NUM_COLS-1:0] columnas_o,
  output logic [1:0]          dato_codc_o,
  output logic [1:0]          dato_codf_o,
  output logic                dato_listo_o,
  output logic                key_pulse_o
);

  localparam int unsigned SCAN_W = $clog2(SCAN_DIV);
  localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [SCAN_W-1:0] SCAN_ONE  = SCAN_W'(1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DEB_W-1:0]  DEB_ONE   = DEB_W'(1);

  logic [NUM_ROWS-1:0] filas_s;
  kp_state_t           state_q, state_d;
  logic [1:0]          col_q, col_d;
  logic [1:0]          row_q, row_d;
  logic [SCAN_W-1:0]   scan_q, scan_d;
  logic [DEB_W-1:0]    deb_q, deb_d;
  logic [1:0]          codc_q, codc_d;
  logic [1:0]          codf_q, codf_d;
  logic                listo_q, listo_d;
  logic                pulse_q, pulse_d;
  logic                row_low;

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned REP_W = $clog2(REPEAT_CYCLES);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
  localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);
  logic [REP_W-1:0] rep_q, rep_d;
`endif

  keypad_sync #(
    .WIDTH(NUM_ROWS)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .din (filas_i),
    .dout(filas_s)
  );

  assign row_low = ~filas_s[row_q];

  // Counts include the sample that caused the state entry, so press and release
  // each need exactly DEBOUNCE_CYCLES consecutive matching samples.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    scan_d  = scan_q;
    deb_d   = deb_q;
    codc_d  = codc_q;
    codf_d  = codf_q;
    listo_d = listo_q;
    pulse_d = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_d   = rep_q;
`endif
    unique case (state_q)
      SCAN: begin
        if (scan_q == SCAN_LAST) begin
          scan_d = '0;
          if (&filas_s) begin
            col_d = col_q + 2'd1;
          end else begin
            row_d   = low_row(filas_s);
            deb_d   = DEB_ONE;
            state_d = DEBOUNCE;
          end
        end else begin
          scan_d = scan_q + SCAN_ONE;
        end
      end
      DEBOUNCE: begin
        if (row_low) begin
          if (deb_q == DEB_LAST) begin
            state_d = HELD;
            codc_d  = col_q;
            codf_d  = row_q;
            listo_d = 1'b0;
            pulse_d = 1'b1;
            deb_d   = '0;
`ifdef KEYPAD_REPEAT_EN
            rep_d   = '0;
`endif
          end else if (deb_q != '1) begin
            deb_d = deb_q + DEB_ONE;
          end
        end else begin
          state_d = SCAN;
          col_d   = col_q + 2'd1;
          deb_d   = '0;
        end
      end
      HELD: begin
        if (!row_low) begin
          state_d = RELEASE;
          deb_d   = DEB_ONE;
        end
`ifdef KEYPAD_REPEAT_EN
        else if (rep_q == REP_LAST) begin
          pulse_d = 1'b1;
          rep_d   = '0;
        end else begin
          rep_d = rep_q + REP_ONE;
        end
`endif
      end
      RELEASE: begin
        if (row_low) begin
          state_d = HELD;
          deb_d   = '0;
`ifdef KEYPAD_REPEAT_EN
          rep_d   = '0;
`endif
        end else if (deb_q == DEB_LAST) begin
          state_d = SCAN;
          listo_d = 1'b1;
          col_d   = col_q + 2'd1;
          deb_d   = '0;
        end else if (deb_q != '1) begin
          deb_d = deb_q + DEB_ONE;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= SCAN;
      col_q   <= '0;
      row_q   <= '0;
      scan_q  <= '0;
      deb_q   <= '0;
      codc_q  <= '0;
      codf_q  <= '0;
      listo_q <= 1'b1;
      pulse_q <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      scan_q  <= scan_d;
      deb_q   <= deb_d;
      codc_q  <= codc_d;
      codf_q  <= codf_d;
      listo_q <= listo_d;
      pulse_q <= pulse_d;
`ifdef KEYPAD_REPEAT_EN
      rep_q   <= rep_d;
`endif
    end
  end

  assign columnas_o   = COL_IDLE & ~(NUM_COLS'(1) << col_q);
  assign dato_codc_o  = codc_q;
  assign dato_codf_o  = codf_q;
  assign dato_listo_o = listo_q;
  assign key_pulse_o  = pulse_q;

endmodule
